// File: rtl/q_ser_pkg.sv
// Shared types and helpers for the serialized-charge transmitter.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
//
// Contents: FSM state enum, tail-length function, parameter range check
// and a small max helper used to size the shared duration timer.
package q_ser_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULSE = 2'd1,
    GAP   = 2'd2,
    TAIL  = 2'd3
  } q_ser_state_t;

  // The tail must outlast the receiver watchdog (2**wtd cycles) by one.
  function automatic int q_ser_tail_cycles(input int wtd);
    return (1 << wtd) + 1;
  endfunction

  // Legal ranges: 1 <= qpp <= 2**bw-1, pd >= 1, 1 <= gap <= 2**wtd-1.
  // The gap bound keeps interior gaps shorter than the receiver timeout.
  function automatic bit q_ser_params_ok(input int bw, input int wtd,
                                         input int qpp, input int pd,
                                         input int gap);
    return (qpp >= 1) && (qpp <= (1 << bw) - 1) && (pd >= 1) &&
           (gap >= 1) && (gap <= (1 << wtd) - 1);
  endfunction

  function automatic int q_ser_max3(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage

// File: rtl/q_ser_timer.sv
// Loadable down-counter shared by the PULSE, GAP and TAIL durations.
// Latency: value updates one cycle after load; expired is combinational on value.
// Backpressure: none; load always wins over the decrement.
//
// Ports:
//   i_clk, i_rst      clock, synchronous active-high reset
//   i_load            load i_load_val on the next edge
//   i_load_val        duration minus one (counter reaches 0 on the last cycle)
//   o_value           current count
//   o_expired         count is zero: this is the last cycle of the interval
module q_ser_timer #(
  parameter int W = 3
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  output logic [W-1:0] o_value,
  output logic         o_expired
);

  logic [W-1:0] r_value;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_value <= '0;
    end else if (i_load) begin
      r_value <= i_load_val;
    end else if (r_value != '0) begin
      r_value <= r_value - 1'b1;
    end
  end

  assign o_value   = r_value;
  assign o_expired = (r_value == '0);

endmodule

// File: rtl/q_serializer.sv
// Serializes a charge value into a frame of fixed-width pulses plus a low tail.
// Latency: first pulse in the cycle after the accepting edge; done after the tail.
// Backpressure: ready low for the whole frame; start while not ready is dropped.
//
// Ports:
//   i_clk, i_rst       clock, synchronous active-high reset
//   i_start, i_q_in    request and charge value, taken when o_ready is high
//   o_ready            idle (also high in the done cycle, which accepts start)
//   o_done             one-cycle end-of-frame pulse
//   o_q_serialized     registered pulse line to the receiver
//   o_n_pulses         pulses emitted in the current / last frame
//
// Build option: define Q_SER_ROUND_EN to round the pulse count to nearest
// (one extra pulse when the remainder is at least half a quantum); the
// default build truncates.
module q_serializer
  import q_ser_pkg::*;
#(
  parameter int BUS_WIDTH      = 10,
  parameter int WTD_BUS_WIDTH  = 2,
  parameter int Q_PER_PULSE    = 30,
  parameter int PULSE_DURATION = 3,
  parameter int GAP_CYCLES     = 1
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_start,
  input  logic [BUS_WIDTH-1:0] i_q_in,
  output logic                 o_ready,
  output logic                 o_done,
  output logic                 o_q_serialized,
  output logic [BUS_WIDTH-1:0] o_n_pulses
);

  localparam int TAIL_CYCLES = q_ser_tail_cycles(WTD_BUS_WIDTH);
  localparam int TMR_MAX     = q_ser_max3(PULSE_DURATION, GAP_CYCLES, TAIL_CYCLES);
  localparam int TMR_W       = $clog2(TMR_MAX + 1);

  localparam logic [TMR_W-1:0]     PULSE_LD = TMR_W'(PULSE_DURATION - 1);
  localparam logic [TMR_W-1:0]     GAP_LD   = TMR_W'(GAP_CYCLES - 1);
  localparam logic [TMR_W-1:0]     TAIL_LD  = TMR_W'(TAIL_CYCLES - 1);
  localparam logic [BUS_WIDTH-1:0] QPP      = BUS_WIDTH'(Q_PER_PULSE);

  if (!q_ser_params_ok(BUS_WIDTH, WTD_BUS_WIDTH, Q_PER_PULSE,
                       PULSE_DURATION, GAP_CYCLES)) begin : g_param_err
    $error("q_serializer: parameter out of range");
  end

  q_ser_state_t         r_state;
  q_ser_state_t         w_state_nxt;
  logic [BUS_WIDTH-1:0] r_q_rem;
  logic [BUS_WIDTH-1:0] r_n_pulses;
  logic                 r_ready;
  logic                 r_done;
  logic                 r_q_ser;

  logic                 w_accept;
  logic [BUS_WIDTH-1:0] w_src;
  logic                 w_full;
  logic                 w_half;
  logic                 w_more;
  logic [BUS_WIDTH-1:0] w_sub;
  logic                 w_enter_pulse;
  logic                 w_done_nxt;
  logic                 w_tmr_load;
  logic [TMR_W-1:0]     w_tmr_load_val;
  logic [TMR_W-1:0]     w_unused_tmr_value;
  logic                 w_tmr_expired;

  q_ser_timer #(
    .W (TMR_W)
  ) u_timer (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_load     (w_tmr_load),
    .i_load_val (w_tmr_load_val),
    .o_value    (w_unused_tmr_value),
    .o_expired  (w_tmr_expired)
  );

  assign w_accept = i_start && (r_state == IDLE);

  // In IDLE the remainder is not latched yet, so the pulse decision and the
  // first subtraction work straight from the input value.
  assign w_src  = (r_state == IDLE) ? i_q_in : r_q_rem;
  assign w_full = (w_src >= QPP);
`ifdef Q_SER_ROUND_EN
  // Extra rounding pulse when 2*rem >= Q_PER_PULSE; widened to avoid overflow.
  assign w_half = (({1'b0, w_src} << 1) >= {1'b0, QPP});
`else
  assign w_half = 1'b0;
`endif
  assign w_more = w_full || w_half;
  // A rounding pulse consumes the whole remainder.
  assign w_sub  = w_full ? (w_src - QPP) : '0;

  assign w_enter_pulse = (w_state_nxt == PULSE) && (r_state != PULSE);

  always_comb begin
    w_state_nxt    = r_state;
    w_tmr_load     = 1'b0;
    w_tmr_load_val = PULSE_LD;
    w_done_nxt     = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_start) begin
          w_tmr_load = 1'b1;
          if (w_more) begin
            w_state_nxt    = PULSE;
            w_tmr_load_val = PULSE_LD;
          end else begin
            w_state_nxt    = TAIL;
            w_tmr_load_val = TAIL_LD;
          end
        end
      end
      PULSE: begin
        if (w_tmr_expired) begin
          w_tmr_load = 1'b1;
          if (w_more) begin
            w_state_nxt    = GAP;
            w_tmr_load_val = GAP_LD;
          end else begin
            w_state_nxt    = TAIL;
            w_tmr_load_val = TAIL_LD;
          end
        end
      end
      GAP: begin
        if (w_tmr_expired) begin
          w_state_nxt    = PULSE;
          w_tmr_load     = 1'b1;
          w_tmr_load_val = PULSE_LD;
        end
      end
      TAIL: begin
        if (w_tmr_expired) begin
          w_state_nxt = IDLE;
          w_done_nxt  = 1'b1;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= IDLE;
      r_ready    <= 1'b1;
      r_done     <= 1'b0;
      r_q_ser    <= 1'b0;
      r_q_rem    <= '0;
      r_n_pulses <= '0;
    end else begin
      r_state <= w_state_nxt;
      // Outputs are registered from the next state so they line up with it.
      r_ready <= (w_state_nxt == IDLE);
      r_done  <= w_done_nxt;
      r_q_ser <= (w_state_nxt == PULSE);
      if (w_enter_pulse) begin
        r_q_rem    <= w_sub;
        r_n_pulses <= (r_state == IDLE) ? BUS_WIDTH'(1) : (r_n_pulses + 1'b1);
      end else if (w_accept) begin
        r_q_rem    <= i_q_in;
        r_n_pulses <= '0;
      end
    end
  end

  assign o_ready        = r_ready;
  assign o_done         = r_done;
  assign o_q_serialized = r_q_ser;
  assign o_n_pulses     = r_n_pulses;

endmodule
